// File: rtl/iob_idbus_arbiter_pkg.sv
// Shared types and constants for the ibus/dbus IOb arbiter.
// Tags name the master that owns an outstanding read.
package iob_idbus_arbiter_pkg;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_I    = 2'd1,
    LOCK_D    = 2'd2
  } lock_e;

  localparam logic TAG_I = 1'b0;
  localparam logic TAG_D = 1'b1;

  localparam int MAX_OUTSTANDING_DEF = 2;

  function automatic lock_e tag2lock(logic tag);
    return tag ? LOCK_D : LOCK_I;
  endfunction

endpackage

// File: rtl/iob_idbus_arbiter_if.sv
// One IOb port: request channel plus read-response channel.
// The master modport issues requests; the slave modport answers them.
interface iob_idbus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                valid;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                ready;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                rready;

  modport master (
    output valid, addr, wdata, wstrb, rready,
    input  ready, rdata, rvalid
  );

  modport slave (
    input  valid, addr, wdata, wstrb, rready,
    output ready, rdata, rvalid
  );

endinterface

// File: rtl/iob_idbus_arbiter_tagq.sv
// 1-bit tag FIFO: remembers which master owns each accepted read.
// Callers never push when full nor pop when empty.
module iob_idbus_arbiter_tagq
  import iob_idbus_arbiter_pkg::*;
#(
  parameter int DEPTH = MAX_OUTSTANDING_DEF,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          tag_i,
  input  logic          pop_i,
  output logic          head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) begin
      mem_d[wr_q] = tag_i;
      wr_d        = nxt(wr_q);
    end
    if (pop_i) begin
      rd_d = nxt(rd_q);
    end
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/iob_idbus_arbiter.sv
// Round-robin merge of the ibus and dbus IOb masters onto one slave.
// Grant locks until accepted; read responses follow a tag queue.
module iob_idbus_arbiter
  import iob_idbus_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  iob_idbus_arbiter_if.slave  ibus,
  iob_idbus_arbiter_if.slave  dbus,
  iob_idbus_arbiter_if.master mem
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  lock_e lock_q, lock_d;
  logic  last_q, last_d;

  logic                gnt_v;
  logic                gnt_tag;
  logic                req_v;
  logic                mem_v;
  logic                accept;
  logic [ADDR_W-1:0]   addr_sel;
  logic [DATA_W-1:0]   wdata_sel;
  logic [DATA_W/8-1:0] wstrb_sel;

  logic          push, pop;
  logic          head;
  logic [CW-1:0] count;
  logic          full;
  logic          has_tag;

  always_comb begin
    gnt_v   = 1'b0;
    gnt_tag = TAG_I;
    unique case (1'b1)
      (lock_q == LOCK_I): begin
        gnt_v   = 1'b1;
        gnt_tag = TAG_I;
      end
      (lock_q == LOCK_D): begin
        gnt_v   = 1'b1;
        gnt_tag = TAG_D;
      end
      default: begin
        if (ibus.valid && dbus.valid) begin
          gnt_v   = 1'b1;
          gnt_tag = ~last_q;
        end else if (ibus.valid) begin
          gnt_v   = 1'b1;
          gnt_tag = TAG_I;
        end else if (dbus.valid) begin
          gnt_v   = 1'b1;
          gnt_tag = TAG_D;
        end
      end
    endcase
  end

  always_comb begin
    req_v     = gnt_tag ? dbus.valid : ibus.valid;
    mem_v     = gnt_v & req_v & ~full & ~rst_i;
    accept    = mem_v & mem.ready;
    addr_sel  = '0;
    wdata_sel = '0;
    wstrb_sel = '0;
    if (mem_v) begin
      addr_sel  = gnt_tag ? dbus.addr  : ibus.addr;
      wdata_sel = gnt_tag ? dbus.wdata : ibus.wdata;
      wstrb_sel = gnt_tag ? dbus.wstrb : ibus.wstrb;
    end
  end

  // A stalled request keeps the grant; any other cycle frees it.
  always_comb begin
    lock_d = LOCK_NONE;
    last_d = last_q;
    if (mem_v && !mem.ready) begin
      lock_d = tag2lock(gnt_tag);
    end
    if (accept) begin
      last_d = gnt_tag;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q <= LOCK_NONE;
      last_q <= TAG_D;
    end else begin
      lock_q <= lock_d;
      last_q <= last_d;
    end
  end

  assign push = accept & (wstrb_sel == '0);

  iob_idbus_arbiter_tagq #(
    .DEPTH (MAX_OUTSTANDING),
    .CW    (CW)
  ) u_tagq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .tag_i   (gnt_tag),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .full_o  (full)
  );

  assign has_tag = (count != '0) & ~rst_i;
  assign pop     = mem.rvalid & mem.rready;

  assign mem.valid  = mem_v;
  assign mem.addr   = addr_sel;
  assign mem.wdata  = wdata_sel;
  assign mem.wstrb  = wstrb_sel;
  assign mem.rready = has_tag &
                      (head ? dbus.rready : ibus.rready);

  assign ibus.ready  = accept & (gnt_tag == TAG_I);
  assign dbus.ready  = accept & (gnt_tag == TAG_D);
  assign ibus.rvalid = mem.rvalid & has_tag & (head == TAG_I);
  assign dbus.rvalid = mem.rvalid & has_tag & (head == TAG_D);
  assign ibus.rdata  = mem.rdata;
  assign dbus.rdata  = mem.rdata;

endmodule

// File: tb/tb_iob_idbus_arbiter.sv
// Directed bench for iob_idbus_arbiter: cycle table plus
// a hand-written locked-write sequence.
module tb_iob_idbus_arbiter;

  localparam logic [31:0] IA = 32'h0000_0000;
  localparam logic [31:0] DA = 32'h8000_0004;
  localparam logic [31:0] DW = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  iob_idbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ibus_if ();
  iob_idbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) dbus_if ();
  iob_idbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  iob_idbus_arbiter #(
    .ADDR_W          (32),
    .DATA_W          (32),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .ibus  (ibus_if),
    .dbus  (dbus_if),
    .mem   (mem_if)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        iv;
    logic [3:0]  iw;
    logic        dv;
    logic [3:0]  dw;
    logic        mr;
    logic        rv;
    logic        irr;
    logic        drr;
    logic        e_mv;
    logic [31:0] e_addr;
    logic        e_ir;
    logic        e_dr;
    logic        e_irv;
    logic        e_drv;
    logic        e_mrr;
  } vec_t;

  vec_t tv[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(
    string n, logic r, logic iv, logic [3:0] iw,
    logic dv, logic [3:0] dw, logic mr, logic rv,
    logic irr, logic drr, logic emv, logic [31:0] ea,
    logic eir, logic edr, logic eirv, logic edrv,
    logic emrr);
    vec_t t;
    t.name = n;   t.rst = r;    t.iv = iv;  t.iw = iw;
    t.dv = dv;    t.dw = dw;    t.mr = mr;  t.rv = rv;
    t.irr = irr;  t.drr = drr;  t.e_mv = emv;
    t.e_addr = ea; t.e_ir = eir; t.e_dr = edr;
    t.e_irv = eirv; t.e_drv = edrv; t.e_mrr = emrr;
    return t;
  endfunction

  task automatic chk(string n, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic drive(logic r, logic iv, logic [3:0] iw,
                       logic dv, logic [3:0] dw, logic mr,
                       logic rv, logic irr, logic drr);
    rst            = r;
    ibus_if.valid  = iv;
    ibus_if.addr   = IA;
    ibus_if.wdata  = 32'h0;
    ibus_if.wstrb  = iw;
    ibus_if.rready = irr;
    dbus_if.valid  = dv;
    dbus_if.addr   = DA;
    dbus_if.wdata  = DW;
    dbus_if.wstrb  = dw;
    dbus_if.rready = drr;
    mem_if.ready   = mr;
    mem_if.rvalid  = rv;
    mem_if.rdata   = 32'h0000_0013;
  endtask

  function automatic logic [63:0] outs();
    return {27'd0, mem_if.valid, mem_if.addr,
            ibus_if.ready, dbus_if.ready,
            ibus_if.rvalid, dbus_if.rvalid, mem_if.rready};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // name rst iv iw dv dw mr rv irr drr | mv addr ir dr irv drv mrr
    tv.push_back(mk("rst_hold",  1,1,0,1,0,1,1,1,1, 0,0, 0,0,0,0,0));
    tv.push_back(mk("i_read",    0,1,0,0,0,1,1,1,1, 1,IA,1,0,0,0,0));
    tv.push_back(mk("i_resp",    0,0,0,0,0,0,1,1,1, 0,0, 0,0,1,0,1));
    tv.push_back(mk("rst_again", 1,0,0,0,0,0,0,0,0, 0,0, 0,0,0,0,0));
    tv.push_back(mk("tie_i",     0,1,0,1,0,1,1,1,1, 1,IA,1,0,0,0,0));
    tv.push_back(mk("tie_d",     0,1,0,1,0,1,1,1,1, 1,DA,0,1,1,0,1));
    tv.push_back(mk("tie_i2",    0,1,0,1,0,1,1,1,1, 1,IA,1,0,0,1,1));
    tv.push_back(mk("tie_d2",    0,1,0,1,0,1,0,1,1, 1,DA,0,1,0,0,1));
    tv.push_back(mk("full_blk",  0,1,0,1,0,1,0,1,1, 0,0, 0,0,0,0,1));
    tv.push_back(mk("full_pop",  0,1,0,1,0,1,1,1,1, 0,0, 0,0,1,0,1));
    tv.push_back(mk("after_pop", 0,1,0,1,0,1,0,1,1, 1,IA,1,0,0,0,1));
    tv.push_back(mk("d_stall1",  0,0,0,0,0,0,1,1,0, 0,0, 0,0,0,1,0));
    tv.push_back(mk("d_stall2",  0,0,0,0,0,0,1,1,0, 0,0, 0,0,0,1,0));
    tv.push_back(mk("d_take",    0,0,0,0,0,0,1,1,1, 0,0, 0,0,0,1,1));
    tv.push_back(mk("i_head",    0,0,0,0,0,0,0,0,1, 0,0, 0,0,0,0,0));
    tv.push_back(mk("i_take",    0,0,0,0,0,0,1,1,1, 0,0, 0,0,1,0,1));
    tv.push_back(mk("empty_rv",  0,0,0,0,0,0,1,1,1, 0,0, 0,0,0,0,0));
    tv.push_back(mk("fill_i",    0,1,0,0,0,1,0,1,1, 1,IA,1,0,0,0,0));
    tv.push_back(mk("fill_d",    0,0,0,1,0,1,0,1,1, 1,DA,0,1,0,0,1));
    tv.push_back(mk("rst_full",  1,1,0,1,0,1,1,1,1, 0,0, 0,0,0,0,0));
    tv.push_back(mk("stray_rv",  0,0,0,0,0,0,1,1,1, 0,0, 0,0,0,0,0));
    tv.push_back(mk("post_rst",  0,1,0,1,0,1,0,1,1, 1,IA,1,0,0,0,0));

    foreach (tv[k]) begin
      @(negedge clk);
      drive(tv[k].rst, tv[k].iv, tv[k].iw, tv[k].dv,
            tv[k].dw, tv[k].mr, tv[k].rv, tv[k].irr,
            tv[k].drr);
      #1;
      chk($sformatf("vec%0d_%s", k, tv[k].name), outs(),
          {27'd0, tv[k].e_mv, tv[k].e_addr, tv[k].e_ir,
           tv[k].e_dr, tv[k].e_irv, tv[k].e_drv,
           tv[k].e_mrr});
    end

    // dbus write held three cycles while ibus waits
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(0, c >= 1, 4'h0, c <= 3, 4'hF, c >= 3,
            0, 1, 1);
      #1;
      if (c <= 3) begin
        chk($sformatf("wr_c%0d_req", c),
            {27'd0, mem_if.valid, mem_if.addr, 4'd0},
            {27'd0, 1'b1, DA, 4'd0});
        chk($sformatf("wr_c%0d_data", c),
            {28'd0, mem_if.wstrb, mem_if.wdata},
            {28'd0, 4'hF, DW});
        chk($sformatf("wr_c%0d_rdy", c),
            {62'd0, ibus_if.ready, dbus_if.ready},
            {62'd0, 1'b0, c == 3});
      end else begin
        chk("wr_c4_igrant",
            {26'd0, mem_if.valid, mem_if.addr,
             mem_if.wstrb, ibus_if.ready, dbus_if.ready},
            {26'd0, 1'b1, IA, 4'h0, 1'b1, 1'b0});
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
    #1;
    chk("rd_resp",
        {29'd0, ibus_if.rvalid, dbus_if.rvalid, ibus_if.rdata},
        {29'd0, 1'b1, 1'b0, 32'h0000_0013});
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
    #1;
    chk("wr_no_tag",
        {61'd0, ibus_if.rvalid, dbus_if.rvalid, mem_if.rready},
        64'd0);

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
